// File: rtl/stream_fifo_param.sv
// stream_fifo_param: parametrised valid/ready FIFO with level, almost-full and synchronous flush
module stream_fifo_param #(
  parameter int DATA_WIDTH        = 8,
  parameter int DEPTH             = 16,
  parameter int ALMOST_FULL_LEVEL = DEPTH - 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       almost_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  if (DATA_WIDTH < 1 || DATA_WIDTH > 64) begin : g_bad_width
    $error("stream_fifo_param: DATA_WIDTH must be 1..64");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("stream_fifo_param: DEPTH must be a power of two >= 2");
  end
  if (ALMOST_FULL_LEVEL < 1 || ALMOST_FULL_LEVEL > DEPTH) begin : g_bad_afl
    $error("stream_fifo_param: ALMOST_FULL_LEVEL must be 1..DEPTH");
  end
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]         level_q, level_d;
  logic                  in_ready_q, almost_full_q;
  logic                  wr, rd;
  assign wr          = in_valid && in_ready_q;
  assign rd          = out_valid && out_ready;
  assign out_valid   = level_q != '0;
  assign out_data    = out_valid ? mem[rd_ptr_q] : '0;
  assign in_ready    = in_ready_q;
  assign level       = level_q;
  assign almost_full = almost_full_q;
  // Next level; flush discards everything including this cycle's transfers
  always_comb level_d = flush ? '0 : level_q + LW'(wr) - LW'(rd);
  // Pointers and registered status flags, derived from next-state level
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      in_ready_q    <= 1'b1;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_q      <= flush ? '0 : wr_ptr_q + AW'(wr);
      rd_ptr_q      <= flush ? '0 : rd_ptr_q + AW'(rd);
      level_q       <= level_d;
      in_ready_q    <= level_d != LW'(DEPTH);
      almost_full_q <= level_d >= LW'(ALMOST_FULL_LEVEL);
    end
  end
  // Storage write; RAM contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (wr && !flush && !rst) mem[wr_ptr_q] <= in_data;
  end
endmodule

// File: tb/tb_stream_fifo_param.sv
// tb_stream_fifo_param: directed checks of order, full, wrap, almost-full, flush/reset and width sweep
module tb_stream_fifo_param;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [63:0] in_data = '0;
  int n_cmp = 0, n_err = 0;
  logic a_ir, a_ov, a_af; logic [7:0]  a_od; logic [2:0] a_lv;
  logic b_ir, b_ov, b_af; logic [7:0]  b_od; logic [4:0] b_lv;
  logic c_ir, c_ov, c_af; logic [0:0]  c_od; logic [1:0] c_lv;
  logic d_ir, d_ov, d_af; logic [63:0] d_od; logic [5:0] d_lv;
  logic [63:0] w1 [3];
  logic [63:0] w2 [2];
  always #5 clk = ~clk;
  stream_fifo_param #(.DATA_WIDTH(8), .DEPTH(4), .ALMOST_FULL_LEVEL(4)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_ir), .in_data(in_data[7:0]),
    .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od), .level(a_lv), .almost_full(a_af));
  stream_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .ALMOST_FULL_LEVEL(12)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_ir), .in_data(in_data[7:0]),
    .out_valid(b_ov), .out_ready(out_ready), .out_data(b_od), .level(b_lv), .almost_full(b_af));
  stream_fifo_param #(.DATA_WIDTH(1), .DEPTH(2), .ALMOST_FULL_LEVEL(2)) u_c (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_ir), .in_data(in_data[0:0]),
    .out_valid(c_ov), .out_ready(out_ready), .out_data(c_od), .level(c_lv), .almost_full(c_af));
  stream_fifo_param #(.DATA_WIDTH(64), .DEPTH(32), .ALMOST_FULL_LEVEL(28)) u_d (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(d_ir), .in_data(in_data),
    .out_valid(d_ov), .out_ready(out_ready), .out_data(d_od), .level(d_lv), .almost_full(d_af));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic reset_all;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; rst = 1'b1;
    step;
    rst = 1'b0;
  endtask
  initial begin
    w1[0] = 64'hDEAD_BEEF_0000_0011; w1[1] = 64'h0123_4567_89AB_CD22; w1[2] = 64'hFFFF_0000_FFFF_0033;
    w2[0] = 64'hFFFF_FFFF_FFFF_FFFF; w2[1] = 64'hA5A5_5A5A_0F0F_F0F0;
    step; reset_all;
    check("rst_in_ready", a_ir, 1); check("rst_out_valid", a_ov, 0); check("rst_out_data", a_od, 0);
    check("rst_level", a_lv, 0); check("rst_af", a_af, 0); check("rst_d_level", d_lv, 0);
    // basic order on DEPTH=4 and DEPTH=32/64-bit
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = w1[i];
      step;
      check("ord_lv_a", a_lv, 64'(i + 1)); check("ord_lv_d", d_lv, 64'(i + 1));
    end
    in_valid = 1'b0;
    check("ord_ov_a", a_ov, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("ord_od_a", a_od, {56'd0, w1[i][7:0]}); check("ord_od_d", d_od, w1[i]);
      step;
      check("ord_lv_rd", a_lv, 64'(2 - i));
    end
    check("ord_ov_end", a_ov, 0); check("ord_d_ov_end", d_ov, 0);
    // width sweep: 1-bit/DEPTH=2 and 64-bit all-ones
    reset_all;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = w2[i];
      step;
    end
    in_valid = 1'b0;
    check("sw_c_lv", c_lv, 2); check("sw_c_ir", c_ir, 0); check("sw_c_af", c_af, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("sw_c_od", c_od, {63'd0, w2[i][0]}); check("sw_d_od", d_od, w2[i]);
      step;
    end
    check("sw_c_ov", c_ov, 0); check("sw_c_ir2", c_ir, 1);
    // full boundary on DEPTH=4
    reset_all;
    in_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_data = 64'(k);
      step;
    end
    check("full_lv", a_lv, 4); check("full_ir", a_ir, 0); check("full_af", a_af, 1);
    in_data = 64'd5;
    step;
    check("full_hold_lv", a_lv, 4);
    out_ready = 1'b1;
    check("full_od", a_od, 1);
    step;
    check("full_rd_lv", a_lv, 3); check("full_rd_ir", a_ir, 1); check("full_rd_af", a_af, 0);
    out_ready = 1'b0;
    step;
    check("full_5th_lv", a_lv, 4);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      check("full_drain_od", a_od, 64'(k));
      step;
    end
    check("full_drain_lv", a_lv, 0);
    // wrap-around with simultaneous push/pop
    reset_all;
    in_valid = 1'b1; in_data = 64'd0;
    step;
    out_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      in_data = 64'(i);
      check("wrap_od", a_od, 64'(i - 1));
      step;
      check("wrap_lv", a_lv, 1);
    end
    in_valid = 1'b0;
    check("wrap_last_od", a_od, 9);
    step;
    check("wrap_end_lv", a_lv, 0);
    // almost_full threshold on DEPTH=16, level 12
    reset_all;
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_data = 64'(i);
      step;
      check("af_fill", b_af, (i + 1 >= 12) ? 64'd1 : 64'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    check("af_rd_lv", b_lv, 11); check("af_rd", b_af, 0);
    // flush mid-operation with a write in the same cycle
    reset_all;
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = 64'h30 + 64'(i);
      step;
    end
    check("fl_pre_lv", a_lv, 3);
    flush = 1'b1; in_data = 64'h77;
    step;
    flush = 1'b0; in_valid = 1'b0;
    check("fl_lv", a_lv, 0); check("fl_ov", a_ov, 0); check("fl_ir", a_ir, 1); check("fl_b_lv", b_lv, 0);
    in_valid = 1'b1; in_data = 64'h44;
    step;
    check("fl_new_od", a_od, 64'h44); check("fl_new_lv", a_lv, 1);
    in_data = 64'h45; step; in_data = 64'h46; step;
    check("rs_pre_lv", a_lv, 3);
    rst = 1'b1; in_data = 64'h88;
    step;
    rst = 1'b0; in_valid = 1'b0;
    check("rs_lv", a_lv, 0); check("rs_ov", a_ov, 0); check("rs_od", a_od, 0);
    check("rs_ir", a_ir, 1); check("rs_d_od", d_od, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
